result_matrix_writeback: RTL and testbench
==========================================

// Module: result_matrix_writeback
// PURPOSE
//  Output-side counterpart of the operand padding/feed path. Captures result matrix C as the
//  systolic array drains it, one element per lane per cycle with lanes arbitrarily skewed,
//  and de-skews it into a max_dim x max_dim buffer. It then writes C back to memory one row
//  per bus beat under a ready handshake. Sits between the systolic array outputs and the
//  memory write port.
// PARAMETERS
//  data_width  32  width of one matrix element
//  bus_width   64  memory bus width; localparam max_dim = bus_width/data_width (default 2)
//  localparam ROW_W = (max_dim>1) ? $clog2(max_dim) : 1
// PORTS
//  clk           in   1                   single clock, rising edge
//  reset         in   1                   synchronous, active-high; clears all state
//  done          in   1                   sync clear, identical effect to reset (end of operation)
//  start_bit     in   1                   arms capture; sampled only in IDLE
//  vector_c      in   max_dim*data_width  lane k = bits [data_width*(k+1)-1 : data_width*k]
//  vector_c_valid in  max_dim             per-lane element valid
//  mem_ready     in   1                   memory accepts the current beat
//  bus_out       out  max_dim*data_width  row data being written
//  write_enable_C out 1                   beat valid
//  row_addr      out  ROW_W               row index of current beat
//  done_write_C  out  1                   all rows written; held high until reset/done
//  overflow_err  out  1                   sticky: valid seen on an already-full lane
// BEHAVIOUR
//  - Reset/done: state=IDLE; bus_out=0, write_enable_C=0, row_addr=0, done_write_C=0,
//    overflow_err=0; lane counters=0; buffer zeroed. Reset/done wins over every other event.
//  - FSM: IDLE -> COLLECT when start_bit=1. COLLECT -> WRITE on the edge after every lane count
//    reaches max_dim. WRITE -> FINISH when the beat with row_addr=max_dim-1 is accepted.
//    FINISH holds until reset/done.
//  - COLLECT: each lane k has its own counter cnt[k] (0..max_dim). When vector_c_valid[k]=1 and
//    cnt[k]<max_dim: C[cnt[k]][k] <= lane k data, then cnt[k]++. Elements arrive row 0 first.
//    Lanes are independent: any skew and any gaps are allowed.
//  - Valid on a lane with cnt[k]==max_dim: data is dropped and overflow_err <= 1 (sticky).
//  - Any vector_c_valid outside COLLECT is ignored, with no error.
//  - Latency: if the last element is captured at edge N, WRITE is entered at edge N+1 and
//    write_enable_C=1 with row 0 on the bus during the cycle after edge N+1.
//  - WRITE: write_enable_C=1; bus_out = C[row_addr] (lane k = C[row_addr][k]);
//    row_addr starts at 0. A beat completes on an edge with write_enable_C && mem_ready, and
//    then row_addr++. While mem_ready=0, bus_out and row_addr hold stable.
//    After the last beat: write_enable_C=0, bus_out=0, row_addr=0, done_write_C=1 on that edge.
//    Throughput is 1 row/cycle with mem_ready held high; total WRITE time = max_dim cycles.
//  - start_bit in COLLECT/WRITE/FINISH is ignored. A new operation requires done or reset.
//  - reset/done mid-COLLECT or mid-WRITE: immediate return to IDLE and the partial matrix is
//    discarded; no further beats are issued.
// CONFIGURATION
//  - WB_TRANSPOSE_EN defined: beat r carries column r, i.e. bus_out lane k = C[k][r].
//    row_addr then means the column index. All timing is unchanged.
//  - WB_TRANSPOSE_EN undefined: row-major writeback as described above.
// TESTING (max_dim=2, data_width=32)
//  1 Aligned drain: start_bit, then both lanes valid for 2 cycles with (1,2) then (3,4),
//    mem_ready=1 -> beats row0=(1,2) and row1=(3,4) on consecutive cycles; done_write_C=1.
//  2 Skew: lane0 valid at cycles 0,1 (5,7); lane1 valid at cycles 1,2 (6,8) ->
//    row0=(5,6), row1=(7,8); WRITE is entered 1 cycle after cycle 2.
//  3 Backpressure: mem_ready=0 for 3 cycles during row0 -> row0 held stable with
//    write_enable_C=1; row1 follows the first cycle mem_ready=1 is accepted.
//  4 Overflow: a third valid on lane0 before lane1 completes -> overflow_err=1;
//    the stored C[*][0] is unchanged.
//  5 Reset mid-WRITE after row0 is accepted -> all outputs return to 0 next cycle;
//    row1 is never written; a later start_bit restarts capture cleanly.
//  6 WB_TRANSPOSE_EN with the stimulus of test 1 -> beats (1,3) then (2,4).

Source files
------------

// File: rtl/result_matrix_writeback.sv
// De-skews the systolic array's drained result matrix into a max_dim x max_dim buffer
// and writes it back one row per bus beat. Define WB_TRANSPOSE_EN for column-major beats.
module result_matrix_writeback #(
    parameter int data_width = 32,
    parameter int bus_width  = 64,
    localparam int max_dim   = bus_width / data_width,
    localparam int ROW_W     = (max_dim > 1) ? $clog2(max_dim) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          done,
    input  logic                          start_bit,
    input  logic [max_dim*data_width-1:0] vector_c,
    input  logic [max_dim-1:0]            vector_c_valid,
    input  logic                          mem_ready,
    output logic [max_dim*data_width-1:0] bus_out,
    output logic                          write_enable_C,
    output logic [ROW_W-1:0]              row_addr,
    output logic                          done_write_C,
    output logic                          overflow_err
);

    localparam int CNT_W = $clog2(max_dim + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q [max_dim];
    logic [CNT_W-1:0]              cnt_d [max_dim];
    logic [data_width-1:0]         mat_q [max_dim][max_dim];
    logic [data_width-1:0]         mat_d [max_dim][max_dim];
    logic [max_dim*data_width-1:0] bus_out_q, bus_out_d;
    logic                          we_q, we_d;
    logic [ROW_W-1:0]              row_q, row_d;
    logic                          done_wr_q, done_wr_d;
    logic                          ovf_q, ovf_d;

    logic                          all_full_s;
    logic [ROW_W-1:0]              sel_row_s;
    logic [max_dim*data_width-1:0] sel_beat_s;

    // Capture is complete once every lane has delivered max_dim elements.
    always_comb begin
        all_full_s = 1'b1;
        for (int k = 0; k < max_dim; k++) begin
            all_full_s = all_full_s & (cnt_q[k] == CNT_W'(max_dim));
        end
    end

    // Beat that will be presented after the next edge: row 0 on entry, else the following row.
    always_comb begin
        sel_row_s  = (state_q == ST_WRITE) ? (row_q + ROW_W'(1)) : '0;
        sel_beat_s = '0;
        for (int r = 0; r < max_dim; r++) begin
            for (int k = 0; k < max_dim; k++) begin
`ifdef WB_TRANSPOSE_EN
                sel_beat_s[k*data_width +: data_width] = sel_beat_s[k*data_width +: data_width] |
                    ((sel_row_s == ROW_W'(r)) ? mat_q[k][r] : '0);
`else
                sel_beat_s[k*data_width +: data_width] = sel_beat_s[k*data_width +: data_width] |
                    ((sel_row_s == ROW_W'(r)) ? mat_q[r][k] : '0);
`endif
            end
        end
    end

    // Next-state and next-output logic for capture and writeback.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mat_d     = mat_q;
        bus_out_d = bus_out_q;
        we_d      = we_q;
        row_d     = row_q;
        done_wr_d = done_wr_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start_bit) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                // Each lane fills its own column top-down, independent of the others.
                for (int k = 0; k < max_dim; k++) begin
                    if (vector_c_valid[k]) begin
                        if (cnt_q[k] == CNT_W'(max_dim)) begin
                            ovf_d = 1'b1;
                        end else begin
                            for (int r = 0; r < max_dim; r++) begin
                                if (cnt_q[k] == CNT_W'(r)) begin
                                    mat_d[r][k] = vector_c[k*data_width +: data_width];
                                end else begin
                                    mat_d[r][k] = mat_q[r][k];
                                end
                            end
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                        end
                    end else begin
                        cnt_d[k] = cnt_q[k];
                    end
                end
                if (all_full_s) begin
                    state_d   = ST_WRITE;
                    we_d      = 1'b1;
                    row_d     = '0;
                    bus_out_d = sel_beat_s;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    if (row_q == ROW_W'(max_dim - 1)) begin
                        state_d   = ST_FINISH;
                        we_d      = 1'b0;
                        bus_out_d = '0;
                        row_d     = '0;
                        done_wr_d = 1'b1;
                    end else begin
                        row_d     = row_q + ROW_W'(1);
                        bus_out_d = sel_beat_s;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_FINISH: begin
                state_d = ST_FINISH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset and done both discard everything.
    always_ff @(posedge clk) begin
        if (reset || done) begin
            state_q   <= ST_IDLE;
            bus_out_q <= '0;
            we_q      <= 1'b0;
            row_q     <= '0;
            done_wr_q <= 1'b0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < max_dim; k++) begin
                cnt_q[k] <= '0;
            end
            for (int r = 0; r < max_dim; r++) begin
                for (int k = 0; k < max_dim; k++) begin
                    mat_q[r][k] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            bus_out_q <= bus_out_d;
            we_q      <= we_d;
            row_q     <= row_d;
            done_wr_q <= done_wr_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            mat_q     <= mat_d;
        end
    end

    assign bus_out        = bus_out_q;
    assign write_enable_C = we_q;
    assign row_addr       = row_q;
    assign done_write_C   = done_wr_q;
    assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_result_matrix_writeback.sv
// Scoreboard bench for result_matrix_writeback (max_dim=2, data_width=32);
// expected beats follow WB_TRANSPOSE_EN when it is defined.
module tb_result_matrix_writeback;

    logic        clk = 1'b0;
    logic        reset, done, start_bit, mem_ready;
    logic [63:0] vector_c;
    logic [1:0]  vector_c_valid;
    logic [63:0] bus_out;
    logic        write_enable_C, done_write_C, overflow_err;
    logic [0:0]  row_addr;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [0:0]  row;
        logic [63:0] data;
    } beat_t;
    beat_t exp_q[$];

    result_matrix_writeback #(.data_width(32), .bus_width(64)) dut (
        .clk(clk), .reset(reset), .done(done), .start_bit(start_bit),
        .vector_c(vector_c), .vector_c_valid(vector_c_valid), .mem_ready(mem_ready),
        .bus_out(bus_out), .write_enable_C(write_enable_C), .row_addr(row_addr),
        .done_write_C(done_write_C), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Beat r of matrix C (c00 c01 / c10 c11); lane 0 is the low word.
    function automatic logic [63:0] exp_bus(input logic [31:0] c00, input logic [31:0] c01,
                                            input logic [31:0] c10, input logic [31:0] c11,
                                            input int r);
`ifdef WB_TRANSPOSE_EN
        return (r == 0) ? {c10, c00} : {c11, c01};
`else
        return (r == 0) ? {c01, c00} : {c11, c10};
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] l0, input logic [31:0] l1);
        vector_c_valid = v;
        vector_c       = {l1, l0};
        cyc();
        vector_c_valid = 2'b00;
        vector_c       = 64'd0;
    endtask

    task automatic push_matrix(input logic [31:0] c00, input logic [31:0] c01,
                               input logic [31:0] c10, input logic [31:0] c11);
        exp_q.push_back({1'b0, exp_bus(c00, c01, c10, c11, 0)});
        exp_q.push_back({1'b1, exp_bus(c00, c01, c10, c11, 1)});
    endtask

    task automatic arm();
        start_bit = 1'b1;
        cyc();
        start_bit = 1'b0;
    endtask

    task automatic clear_op();
        done = 1'b1;
        cyc();
        done = 1'b0;
    endtask

    // Called right after the edge capturing the last element: WRITE must start one edge later.
    task automatic check_entry(input string tag);
        check({tag, "_we_before"}, {63'd0, write_enable_C}, 64'd0);
        cyc();
        check({tag, "_we_entry"}, {63'd0, write_enable_C}, 64'd1);
        check({tag, "_row_entry"}, {63'd0, row_addr}, 64'd0);
    endtask

    task automatic check_finished(input string tag);
        check({tag, "_done"}, {63'd0, done_write_C}, 64'd1);
        check({tag, "_we_off"}, {63'd0, write_enable_C}, 64'd0);
        check({tag, "_bus_zero"}, bus_out, 64'd0);
        check({tag, "_row_zero"}, {63'd0, row_addr}, 64'd0);
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && !done && write_enable_C && mem_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got row %0d data %0h expected no beat", row_addr, bus_out);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if ({row_addr, bus_out} !== e) begin
                    bad++;
                    $display("FAIL beat: got row %0d data %0h expected row %0d data %0h",
                             row_addr, bus_out, e.row, e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; done = 1'b0; start_bit = 1'b0; mem_ready = 1'b1;
        vector_c = 64'd0; vector_c_valid = 2'b00;
        cyc(); cyc();
        reset = 1'b0;
        check("rst_bus", bus_out, 64'd0);
        check("rst_we", {63'd0, write_enable_C}, 64'd0);
        check("rst_row", {63'd0, row_addr}, 64'd0);
        check("rst_done", {63'd0, done_write_C}, 64'd0);
        check("rst_ovf", {63'd0, overflow_err}, 64'd0);

        // Aligned drain
        arm();
        push_matrix(32'd1, 32'd2, 32'd3, 32'd4);
        drive(2'b11, 32'd1, 32'd2);
        drive(2'b11, 32'd3, 32'd4);
        check_entry("t1");
        cyc(); cyc();
        check_finished("t1");
        drive(2'b11, 32'd9, 32'd9);
        check("t1_valid_ignored_ovf", {63'd0, overflow_err}, 64'd0);
        check("t1_done_held", {63'd0, done_write_C}, 64'd1);
        clear_op();
        check("clr_done", {63'd0, done_write_C}, 64'd0);

        // Skewed lanes
        arm();
        push_matrix(32'd5, 32'd6, 32'd7, 32'd8);
        drive(2'b01, 32'd5, 32'd0);
        drive(2'b11, 32'd7, 32'd6);
        drive(2'b10, 32'd0, 32'd8);
        check_entry("t2");
        cyc(); cyc();
        check_finished("t2");
        clear_op();

        // Backpressure on row 0
        mem_ready = 1'b0;
        arm();
        push_matrix(32'd1, 32'd2, 32'd3, 32'd4);
        drive(2'b11, 32'd1, 32'd2);
        drive(2'b11, 32'd3, 32'd4);
        check_entry("t3");
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_we", {63'd0, write_enable_C}, 64'd1);
            check("t3_hold_row", {63'd0, row_addr}, 64'd0);
            check("t3_hold_bus", bus_out, exp_bus(32'd1, 32'd2, 32'd3, 32'd4, 0));
            cyc();
        end
        mem_ready = 1'b1;
        cyc();
        check("t3_row1", {63'd0, row_addr}, 64'd1);
        cyc();
        check_finished("t3");
        clear_op();

        // Overflow on lane 0 before lane 1 completes
        arm();
        push_matrix(32'd10, 32'd20, 32'd30, 32'd40);
        drive(2'b01, 32'd10, 32'd0);
        drive(2'b01, 32'd30, 32'd0);
        check("t4_no_ovf_yet", {63'd0, overflow_err}, 64'd0);
        drive(2'b01, 32'd99, 32'd0);
        check("t4_ovf", {63'd0, overflow_err}, 64'd1);
        drive(2'b10, 32'd0, 32'd20);
        drive(2'b10, 32'd0, 32'd40);
        check_entry("t4");
        cyc(); cyc();
        check_finished("t4");
        check("t4_ovf_sticky", {63'd0, overflow_err}, 64'd1);
        clear_op();
        check("t4_ovf_cleared", {63'd0, overflow_err}, 64'd0);

        // Reset mid-WRITE after row 0 is accepted
        arm();
        exp_q.push_back({1'b0, exp_bus(32'd1, 32'd2, 32'd3, 32'd4, 0)});
        drive(2'b11, 32'd1, 32'd2);
        drive(2'b11, 32'd3, 32'd4);
        check_entry("t5");
        cyc();
        check("t5_row1_pending", {63'd0, row_addr}, 64'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t5_we", {63'd0, write_enable_C}, 64'd0);
        check("t5_bus", bus_out, 64'd0);
        check("t5_row", {63'd0, row_addr}, 64'd0);
        check("t5_done", {63'd0, done_write_C}, 64'd0);
        cyc(); cyc();
        check("t5_quiet", {63'd0, write_enable_C}, 64'd0);

        // Clean restart after reset
        arm();
        push_matrix(32'd5, 32'd6, 32'd7, 32'd8);
        drive(2'b01, 32'd5, 32'd0);
        drive(2'b11, 32'd7, 32'd6);
        drive(2'b10, 32'd0, 32'd8);
        check_entry("t5r");
        cyc(); cyc();
        check_finished("t5r");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
